// File: rtl/program_counter.sv
// program_counter: 8-bit fetch PC sequenced by a RUN / REDIRECT / HOLD FSM.
// Define CALL_STACK_EN to add a 4-entry return-address stack (Call/Return).
module program_counter (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Clear,
    input  logic       Stall,
    input  logic       Branch_Taken,
    input  logic [7:0] Jump_Address,
    input  logic       Call,
    input  logic       Return,
    output logic [7:0] PC,
    output logic [7:0] PC_Added,
    output logic       Fetch_Valid,
    output logic       Flush,
    output logic       Stack_Error
);
    typedef enum logic [1:0] {RUN, REDIRECT, HOLD} state_t;

    state_t     state;
    logic       fresh;
    logic       do_ret;
    logic       do_call;
    logic [7:0] ret_addr;

    assign PC_Added = PC + 8'd1;
    // Only the first edge out of reset sees RUN without a valid fetch.
    assign fresh = (state == RUN) && !Fetch_Valid;

`ifdef CALL_STACK_EN
    logic [7:0] stack [4];
    logic [1:0] sp;
    logic [1:0] top;
    logic [2:0] depth;

    assign top      = sp - 2'd1;
    assign do_ret   = Return && !Clear && !Branch_Taken;
    assign do_call  = Call && !Return && !Clear && !Branch_Taken;
    assign ret_addr = (depth == 3'd0) ? 8'h00 : stack[top];

    always_ff @(posedge Clock) begin
        if (do_call)
            stack[sp] <= PC_Added;
    end

    // depth counts outstanding calls, so a wrapped pointer pops overwritten slots.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sp          <= 2'd0;
            depth       <= 3'd0;
            Stack_Error <= 1'b0;
        end else if (Clear) begin
            sp    <= 2'd0;
            depth <= 3'd0;
        end else if (do_ret) begin
            if (depth == 3'd0) begin
                Stack_Error <= 1'b1;
            end else begin
                sp    <= top;
                depth <= depth - 3'd1;
            end
        end else if (do_call) begin
            sp <= sp + 2'd1;
            if (depth != 3'd7)
                depth <= depth + 3'd1;
        end
    end
`else
    logic unused_strobes;

    assign unused_strobes = Call ^ Return;
    assign do_ret         = 1'b0;
    assign do_call        = 1'b0;
    assign ret_addr       = 8'h00;
    assign Stack_Error    = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= RUN;
            PC          <= 8'h00;
            Fetch_Valid <= 1'b0;
            Flush       <= 1'b0;
        end else if (Clear) begin
            state       <= RUN;
            PC          <= 8'h00;
            Fetch_Valid <= 1'b1;
            Flush       <= 1'b0;
        end else if (Branch_Taken || do_ret || do_call) begin
            state       <= REDIRECT;
            PC          <= do_ret ? ret_addr : Jump_Address;
            Fetch_Valid <= 1'b0;
            Flush       <= 1'b1;
        end else if (Stall) begin
            state       <= HOLD;
            Fetch_Valid <= 1'b0;
            Flush       <= 1'b0;
        end else begin
            state       <= RUN;
            Fetch_Valid <= 1'b1;
            Flush       <= 1'b0;
            if (!fresh)
                PC <= PC_Added;
        end
    end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: vector table, randomized run against a behavioural
// model, and hand sequences for reset, stall, redirect and call-stack cases.
module tb_program_counter;
    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       Clear, Stall, Branch_Taken, Call, Return;
    logic [7:0] Jump_Address;
    logic [7:0] PC, PC_Added;
    logic       Fetch_Valid, Flush, Stack_Error;

`ifdef CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    program_counter dut (
        .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear), .Stall(Stall),
        .Branch_Taken(Branch_Taken), .Jump_Address(Jump_Address),
        .Call(Call), .Return(Return), .PC(PC), .PC_Added(PC_Added),
        .Fetch_Valid(Fetch_Valid), .Flush(Flush), .Stack_Error(Stack_Error)
    );

    always #5 Clock = ~Clock;

    int passed = 0;
    int total  = 0;

    // Reference model: plain integers and a 4-slot circular array.
    int m_pc, m_fv, m_fl, m_err, m_fresh, m_sp, m_depth;
    int m_stk [4];

    typedef struct {
        bit       clr, stl, bt;
        bit [7:0] ja;
        bit [7:0] pc;
        bit       fv, fl;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 0; m_fv = 0; m_fl = 0; m_err = 0;
        m_fresh = 1; m_sp = 0; m_depth = 0;
    endtask

    task automatic model_step();
        if (Clear) begin
            m_pc = 0; m_fv = 1; m_fl = 0; m_sp = 0; m_depth = 0;
        end else if (Branch_Taken) begin
            m_pc = Jump_Address; m_fv = 0; m_fl = 1;
        end else if (STK && Return) begin
            if (m_depth == 0) begin
                m_pc = 0; m_err = 1;
            end else begin
                m_sp = (m_sp + 3) % 4; m_pc = m_stk[m_sp]; m_depth--;
            end
            m_fv = 0; m_fl = 1;
        end else if (STK && Call) begin
            m_stk[m_sp] = (m_pc + 1) % 256; m_sp = (m_sp + 1) % 4;
            if (m_depth < 7) m_depth++;
            m_pc = Jump_Address; m_fv = 0; m_fl = 1;
        end else if (Stall) begin
            m_fv = 0; m_fl = 0;
        end else begin
            if (m_fresh == 0) m_pc = (m_pc + 1) % 256;
            m_fv = 1; m_fl = 0;
        end
        m_fresh = 0;
    endtask

    task automatic drive(input bit c, input bit s, input bit b,
                         input bit [7:0] ja, input bit ca, input bit r);
        Clear = c; Stall = s; Branch_Taken = b;
        Jump_Address = ja; Call = ca; Return = r;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_pc"}, PC, m_pc);
        chk({tag, "_pc_added"}, PC_Added, (m_pc + 1) % 256);
        chk({tag, "_fv"}, Fetch_Valid, m_fv);
        chk({tag, "_flush"}, Flush, m_fl);
        chk({tag, "_err"}, Stack_Error, m_err);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 8'h00, 0, 0);
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        #1;
    endtask

    initial begin
        tbl = '{
            '{0,0,0,8'h00, 8'h00,1,0}, '{0,0,0,8'h00, 8'h01,1,0},
            '{0,0,0,8'h00, 8'h02,1,0}, '{0,0,0,8'h00, 8'h03,1,0},
            '{0,0,0,8'h00, 8'h04,1,0}, '{0,0,0,8'h00, 8'h05,1,0},
            '{0,1,0,8'h00, 8'h05,0,0}, '{0,1,0,8'h00, 8'h05,0,0},
            '{0,1,0,8'h00, 8'h05,0,0}, '{0,0,0,8'h00, 8'h06,1,0},
            '{0,1,0,8'h00, 8'h06,0,0}, '{0,1,1,8'h80, 8'h80,0,1},
            '{0,0,0,8'h00, 8'h81,1,0}, '{0,0,1,8'h10, 8'h10,0,1},
            '{0,0,1,8'h20, 8'h20,0,1}, '{0,1,0,8'h00, 8'h20,0,0},
            '{0,0,0,8'h00, 8'h21,1,0}, '{1,0,1,8'h40, 8'h00,1,0},
            '{0,0,0,8'h00, 8'h01,1,0}, '{0,0,1,8'hFF, 8'hFF,0,1},
            '{0,0,0,8'h00, 8'h00,1,0}, '{1,0,0,8'h00, 8'h00,1,0},
            '{0,0,0,8'h00, 8'h01,1,0}
        };

        do_reset();
        chk("reset_pc", PC, 8'h00);
        chk("reset_fv", Fetch_Valid, 0);
        chk("reset_flush", Flush, 0);
        chk("reset_err", Stack_Error, 0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].clr, tbl[i].stl, tbl[i].bt, tbl[i].ja, 0, 0);
            tick();
            chk($sformatf("vec%0d_pc", i), PC, tbl[i].pc);
            chk($sformatf("vec%0d_fv", i), Fetch_Valid, tbl[i].fv);
            chk($sformatf("vec%0d_flush", i), Flush, tbl[i].fl);
        end

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(31) == 0, $urandom_range(3) == 0,
                  $urandom_range(7) == 0, 8'($urandom),
                  $urandom_range(9) == 0, $urandom_range(9) == 0);
            tick();
            check_model("rand");
        end

        do_reset();
        for (int i = 0; i < 260; i++) begin
            tick();
            chk("free_run_pc", PC, i % 256);
            chk("free_run_fv", Fetch_Valid, 1);
        end

        do_reset();
        repeat (17) tick();
        chk("pre_branch_pc", PC, 8'h10);
        drive(0, 0, 1, 8'h80, 0, 0);
        tick();
        chk("branch_pc", PC, 8'h80);
        chk("branch_flush", Flush, 1);
        chk("branch_fv", Fetch_Valid, 0);
        drive(0, 0, 0, 8'h00, 0, 0);
        tick();
        chk("after_branch_pc", PC, 8'h81);
        chk("after_branch_flush", Flush, 0);

        drive(0, 0, 1, 8'h33, 0, 0);
        tick();
        chk("mid_redirect_flush", Flush, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_pc", PC, 8'h00);
        chk("async_rst_flush", Flush, 0);
        chk("async_rst_fv", Fetch_Valid, 0);
        do_reset();
        tick();
        chk("post_rst_pc", PC, 8'h00);
        chk("post_rst_flush", Flush, 0);

        drive(0, 0, 0, 8'h00, 0, 0);
        tick();
        drive(0, 1, 0, 8'h00, 0, 0);
        tick();
        chk("mid_hold_pc", PC, 8'h01);
        #2 Reset_n = 1'b0;
        #1;
        chk("hold_rst_pc", PC, 8'h00);
        chk("hold_rst_fv", Fetch_Valid, 0);
        do_reset();

`ifdef CALL_STACK_EN
        tick();
        drive(0, 0, 1, 8'h20, 0, 0);
        tick();
        drive(0, 0, 0, 8'h60, 1, 0);
        tick();
        chk("call_pc", PC, 8'h60);
        chk("call_flush", Flush, 1);
        drive(0, 0, 0, 8'h00, 0, 0);
        tick();
        drive(0, 0, 0, 8'h00, 0, 1);
        tick();
        chk("ret_pc", PC, 8'h21);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 8'(8'hA0 + 8'(i * 16)), 1, 0);
            tick();
        end
        chk("call5_pc", PC, 8'hE0);
        begin
            bit [7:0] exp_ret [5];
            exp_ret = '{8'hD1, 8'hC1, 8'hB1, 8'hA1, 8'hD1};
            for (int i = 0; i < 5; i++) begin
                drive(0, 0, 0, 8'h00, 0, 1);
                tick();
                chk($sformatf("ret%0d_pc", i), PC, exp_ret[i]);
                chk($sformatf("ret%0d_err", i), Stack_Error, 0);
            end
        end
        tick();
        chk("empty_ret_pc", PC, 8'h00);
        chk("empty_ret_err", Stack_Error, 1);
        drive(1, 0, 0, 8'h00, 0, 0);
        tick();
        chk("clear_keeps_err", Stack_Error, 1);
        drive(0, 0, 0, 8'h00, 0, 0);
        do_reset();
        chk("rst_clears_err", Stack_Error, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
